// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the ALU issue controller: the ALU select codes
//   understood by the shared ALU, and the issue FSM state encoding.
//   No ports; imported by the controller, its arbiter and the testbench.
// -----------------------------------------------------------------------------
package alu_pkg;

   // ALU select codes (5-bit S input of the shared ALU)
   localparam logic [4:0] OP_NOP    = 5'h00;
   localparam logic [4:0] OP_ADD    = 5'h01;
   localparam logic [4:0] OP_SUB    = 5'h02;
   localparam logic [4:0] OP_AND    = 5'h03;
   localparam logic [4:0] OP_OR     = 5'h04;
   localparam logic [4:0] OP_XOR    = 5'h05;
   localparam logic [4:0] OP_SLL    = 5'h06;
   localparam logic [4:0] OP_SRL    = 5'h07;
   localparam logic [4:0] OP_SRA    = 5'h08;
   localparam logic [4:0] OP_SLT    = 5'h09;
   localparam logic [4:0] OP_SLTU   = 5'h0A;
   localparam logic [4:0] OP_MUL    = 5'h0B;
   localparam logic [4:0] OP_MULH   = 5'h0C;
   localparam logic [4:0] OP_MULHU  = 5'h0D;
   localparam logic [4:0] OP_MULHSU = 5'h0E;
   localparam logic [4:0] OP_BEQ    = 5'h0F;
   localparam logic [4:0] OP_BNE    = 5'h10;
   localparam logic [4:0] OP_BLT    = 5'h11;
   localparam logic [4:0] OP_BGE    = 5'h12;
   localparam logic [4:0] OP_BLTU   = 5'h13;
   localparam logic [4:0] OP_BGEU   = 5'h14;
   localparam logic [4:0] OP_LUI    = 5'h15;
   localparam logic [4:0] OP_AUIPC  = 5'h16;

   // Issue FSM state encoding (plain constants keep the encoding visible
   // to legacy tools and to anyone probing the state register directly)
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t EXEC = 2'd1;
   localparam state_t DONE = 2'd2;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_req_if / alu_rsp_if
//   alu_req_if : one requester's op channel (valid/ready + a, b, op).
//                master = requester, slave = issue controller.
//   alu_rsp_if : result channel (valid/ready + id, q, cmp).
//                master = issue controller, slave = result consumer.
// -----------------------------------------------------------------------------
interface alu_req_if #(
   parameter int XLEN = 32,
   parameter int OPW  = 5
);
   logic            valid;
   logic            ready;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [OPW-1:0]  op;

   modport master (output valid, output a, output b, output op, input  ready);
   modport slave  (input  valid, input  a, input  b, input  op, output ready);
endinterface

interface alu_rsp_if #(
   parameter int XLEN = 32
);
   logic            valid;
   logic            ready;
   logic            id;
   logic [XLEN-1:0] q;
   logic            cmp;

   modport master (output valid, output id, output q, output cmp, input  ready);
   modport slave  (input  valid, input  id, input  q, input  cmp, output ready);
endinterface

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant. A lone valid requester always wins; when both
//   are valid the one that was NOT granted last time wins.
//   req_valid [1:0] in  : valid vector (bit N = requester N)
//   rr_last         in  : id of the most recently granted requester
//   gnt       [1:0] out : one-hot grant, zero when nobody is valid
//   gnt_id          out : index of the granted requester (0 when none)
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       rr_last,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the case leaves it unassigned (which would infer a latch).
      gnt_id = 1'b0;
      gnt    = 2'b00;
      case (req_valid)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ~rr_last;
         default: gnt_id = 1'b0;
      endcase
      if (|req_valid) begin
         gnt = gnt_id ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Shares one combinational ALU between requester 0 (execute stage) and
//   requester 1 (branch/address unit). Round-robin arbitration, operands and
//   select registered into the ALU, MUL held for MUL_LAT cycles, result
//   returned with the requester id over a valid/ready response channel.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   req0, req1        : alu_req_if.slave op channels
//   alu_a/alu_b/alu_s : registered ALU operands and select (alu_s=0 outside EXEC)
//   alu_q/alu_cmp     : combinational ALU result and compare flag
//   rsp               : alu_rsp_if.master result channel
// -----------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int OPW     = 5,
   parameter int MUL_LAT = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_req_if.slave        req0,
   alu_req_if.slave        req1,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [OPW-1:0]  alu_s,
   input  logic [XLEN-1:0] alu_q,
   input  logic            alu_cmp,
   alu_rsp_if.master       rsp
);

   // Counter only has to hold MUL_LAT-1; keep at least one bit
   localparam int                CNT_W   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [CNT_W-1:0]  MUL_CNT = CNT_W'(MUL_LAT - 1);

   state_t            state_q,    state_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic              rr_last_q,  rr_last_d;
   logic              id_q,       id_d;
   logic [XLEN-1:0]   alu_a_q,    alu_a_d;
   logic [XLEN-1:0]   alu_b_q,    alu_b_d;
   logic [OPW-1:0]    alu_s_q,    alu_s_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q,   rsp_id_d;
   logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
   logic              rsp_cmp_q,  rsp_cmp_d;

   logic [1:0]        gnt;
   logic              gnt_id;
   logic [XLEN-1:0]   sel_a;
   logic [XLEN-1:0]   sel_b;
   logic [OPW-1:0]    sel_op;

   rr_arb2 u_arb (
      .req_valid ({req1.valid, req0.valid}),
      .rr_last   (rr_last_q),
      .gnt       (gnt),
      .gnt_id    (gnt_id)
   );

   // Grant already implies valid, so ready is simply "idle and granted";
   // in IDLE a non-zero grant therefore means an op is accepted this cycle.
   assign req0.ready = (state_q == IDLE) & gnt[0];
   assign req1.ready = (state_q == IDLE) & gnt[1];

   assign sel_a  = gnt_id ? req1.a  : req0.a;
   assign sel_b  = gnt_id ? req1.b  : req0.b;
   assign sel_op = gnt_id ? req1.op : req0.op;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_last_d   = rr_last_q;
      id_d        = id_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_s_d     = alu_s_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_cmp_d   = rsp_cmp_q;

      case (state_q)
         IDLE: begin
            if (|gnt) begin
               alu_a_d   = sel_a;
               alu_b_d   = sel_b;
               alu_s_d   = sel_op;
               id_d      = gnt_id;
               rr_last_d = gnt_id;
               // Only MUL stretches EXEC; every other code (including
               // undefined ones) is executed for a single cycle.
               cnt_d     = (sel_op == OPW'(OP_MUL)) ? MUL_CNT : '0;
               state_d   = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               rsp_data_d  = alu_q;
               rsp_cmp_d   = alu_cmp;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               alu_s_d     = '0;
               state_d     = DONE;
            end
         end
         DONE: begin
            // Result stays put until the consumer takes it
            if (rsp.ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            alu_s_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rr_last_q   <= 1'b1;   // makes req0 win the first tie
         id_q        <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_s_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_cmp_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // pre-edge value of the others, independent of statement order.
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_last_q   <= rr_last_d;
         id_q        <= id_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_s_q     <= alu_s_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_cmp_q   <= rsp_cmp_d;
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_s     = alu_s_q;
   assign rsp.valid = rsp_valid_q;
   assign rsp.id    = rsp_id_q;
   assign rsp.q     = rsp_data_q;
   assign rsp.cmp   = rsp_cmp_q;

endmodule
